uart_msg_sender: RTL and testbench

Message serializer between the demo state machine and `uart_tx`. It accepts whole fixed-length text messages (for example "STATE_3" padded, plus CR LF) on a single-cycle valid/ready port and queues them in a small FIFO. It streams each message byte-by-byte into `uart_tx` over the `tx_data_valid`/`tx_data_ready` handshake, and interleaves echo bytes from `uart_rx` only at message boundaries. It replaces the ad-hoc `printf` latch and SEND/WAIT logic in the top level.

---
 rtl/uart_msg_pkg.sv | 27 ++
 rtl/uart_msg_sender_if.sv | 37 +++
 rtl/uart_msg_fifo.sv | 65 ++++++
 rtl/uart_msg_sender.sv | 141 ++++++++++++++
 tb/tb_uart_msg_sender.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_msg_pkg.sv
// -----------------------------------------------------------------------------
// uart_msg_pkg
// Shared definitions for the UART message sender: FSM state encoding, the
// default message length, the drop counter width and a saturating add helper
// for that counter.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        ECHO = 2'd2
    } state_t;

    localparam int MSG_BYTES_DEF = 21;
    localparam int DROP_W        = 8;

    // Adds 0..2 to the drop counter and sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [1:0]        inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {{(DROP_W-1){1'b0}}, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/uart_msg_sender_if.sv
// -----------------------------------------------------------------------------
// uart_msg_sender_if
// Bundles the three streams around the message sender:
//   msg_data/msg_valid/msg_ready     message producer -> sender
//   echo_data/echo_valid             uart_rx echo bytes -> sender (no ready)
//   tx_data/tx_data_valid/tx_data_ready  sender -> uart_tx
// Handshake rule for both valid/ready pairs: a transfer happens on a rising
// sys_clk edge where valid && ready are both 1. Once a sender raises valid it
// keeps valid high and data stable until that transfer edge (reset excepted);
// ready may change freely and never depends on a future valid.
// echo_valid is a single-cycle strobe with no back-pressure.
// Modports: slave = the uart_msg_sender view, master = the environment view.
// -----------------------------------------------------------------------------
interface uart_msg_sender_if
    import uart_msg_pkg::*;
#(
    parameter int MSG_BYTES = MSG_BYTES_DEF
);
    logic [MSG_BYTES*8-1:0] msg_data;
    logic                   msg_valid;
    logic                   msg_ready;
    logic [7:0]             echo_data;
    logic                   echo_valid;
    logic [7:0]             tx_data;
    logic                   tx_data_valid;
    logic                   tx_data_ready;

    modport slave (
        input  msg_data, msg_valid, echo_data, echo_valid, tx_data_ready,
        output msg_ready, tx_data, tx_data_valid
    );

    modport master (
        output msg_data, msg_valid, echo_data, echo_valid, tx_data_ready,
        input  msg_ready, tx_data, tx_data_valid
    );
endinterface

// File: rtl/uart_msg_fifo.sv
// -----------------------------------------------------------------------------
// uart_msg_fifo
// DEPTH-entry register FIFO holding whole messages.
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   push, push_data      write request and payload (ignored when full)
//   pop                  drop the head entry (ignored when empty)
//   head                 current head entry (valid when !empty)
//   count                occupancy, 0..DEPTH
//   full, empty          occupancy flags
// -----------------------------------------------------------------------------
module uart_msg_fifo
    import uart_msg_pkg::*;
#(
    parameter  int WIDTH = MSG_BYTES_DEF * 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Payload storage carries no reset; count/pointers define what is valid.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_msg_sender.sv
// -----------------------------------------------------------------------------
// uart_msg_sender
// Queues fixed-length messages and streams them byte-by-byte (leftmost char
// first) into uart_tx. Echo bytes from uart_rx are held in a one-byte register
// and sent only between messages, with priority over the next queued message.
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   bus (slave)          message, echo and uart_tx streams
//   busy                 FSM active, FIFO non-empty or echo byte pending
//   drop_cnt             saturating count of refused messages + echo bytes
//   fsm_state            current FSM state (observation only)
// -----------------------------------------------------------------------------
module uart_msg_sender
    import uart_msg_pkg::*;
#(
    parameter int MSG_BYTES = MSG_BYTES_DEF,
    parameter int DEPTH     = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    uart_msg_sender_if.slave    bus,
    output logic                busy,
    output logic [DROP_W-1:0]   drop_cnt,
    output state_t              fsm_state
);
    localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [7:0]             echo_byte;
    logic                   echo_full;
    logic [MSG_BYTES*8-1:0] head;
    logic [CNT_W-1:0]       count;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic tx_hs, msg_hs, echo_hs, last_byte;
    logic accept, drop_msg, echo_store, echo_drop;

    assign tx_hs     = bus.tx_data_valid && bus.tx_data_ready;
    assign msg_hs    = (state == MSG) && tx_hs;
    assign echo_hs   = (state == ECHO) && tx_hs;
    assign last_byte = (idx == IDX_W'(MSG_BYTES - 1));

    // msg_ready comes straight from the registered occupancy, so a push that
    // coincides with a pop on a full FIFO is still refused.
    assign bus.msg_ready = !fifo_full;
    assign accept        = bus.msg_valid && bus.msg_ready;
    assign drop_msg      = bus.msg_valid && !bus.msg_ready;

    // The held byte leaving on this edge frees the register for a new arrival.
    assign echo_store = bus.echo_valid && (!echo_full || echo_hs);
    assign echo_drop  = bus.echo_valid && echo_full && !echo_hs;

    assign busy      = (state != IDLE) || (count != '0) || echo_full;
    assign fsm_state = state;

    uart_msg_fifo #(
        .WIDTH (MSG_BYTES * 8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (accept),
        .push_data (bus.msg_data),
        .pop       (msg_hs && last_byte),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic; a pending echo wins over the next message, but only
    // from IDLE, so a message is never split.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (echo_full)        state_nxt = ECHO;
                else if (!fifo_empty) state_nxt = MSG;
            end
            MSG:     if (msg_hs && last_byte) state_nxt = IDLE;
            ECHO:    if (echo_hs)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; data comes from registers that do not move until the
    // handshake, which keeps tx_data stable while valid is waiting.
    always_comb begin
        bus.tx_data_valid = 1'b0;
        bus.tx_data       = 8'h00;
        case (state)
            MSG: begin
                bus.tx_data_valid = 1'b1;
                bus.tx_data       = head[8*(MSG_BYTES-1-int'(idx)) +: 8];
            end
            ECHO: begin
                bus.tx_data_valid = 1'b1;
                bus.tx_data       = echo_byte;
            end
            default: ;
        endcase
    end

    // Byte index within the current message.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                 idx <= '0;
        else if (state == IDLE)         idx <= '0;
        else if (msg_hs && !last_byte)  idx <= idx + 1'b1;
    end

    // Echo holding register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            echo_byte <= 8'h00;
            echo_full <= 1'b0;
        end else begin
            if (echo_store) begin
                echo_byte <= bus.echo_data;
                echo_full <= 1'b1;
            end else if (echo_hs) begin
                echo_full <= 1'b0;
            end
        end
    end

    // Drop counter; a message drop and an echo drop on one edge add 2.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) drop_cnt <= '0;
        else            drop_cnt <= sat_add(drop_cnt, 2'(drop_msg) + 2'(echo_drop));
    end
endmodule

// File: tb/tb_uart_msg_sender.sv
// -----------------------------------------------------------------------------
// tb_uart_msg_sender
// Drives messages and echo bytes into uart_msg_sender, models uart_tx as a
// ready source with programmable busy time, and checks every transmitted byte
// against an expected-byte queue built from the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_msg_sender;
    import uart_msg_pkg::*;

    localparam int NB    = 21;
    localparam int DEPTH = 2;
    localparam int W     = 8;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    uart_msg_sender_if #(.MSG_BYTES(NB)) bus ();
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;
    state_t            fsm_state;

    uart_msg_sender #(.MSG_BYTES(NB), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    // uart_tx model controls
    bit force_low = 1'b0;
    int busy_time = 0;
    int busy_left = 0;
    assign bus.tx_data_ready = !force_low && (busy_left == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NB*8-1:0] make_msg(input int n);
        logic [7:0] dig;
        dig = 8'(8'h30 + n);
        return {"STATE_", dig, {12{8'h20}}, 8'h0D, 8'h0A};
    endfunction

    // ---------------- uart_tx model + output monitor ----------------
    initial begin : monitor
        bit           hs;
        bit           pend;
        logic [7:0]   pdata;
        logic [W-1:0] e;
        hs = 1'b0;
        pend = 1'b0;
        pdata = 8'h00;
        forever begin
            @(negedge sys_clk);
            hs = 1'b0;
            if (!sys_rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("hold_valid", 32'(bus.tx_data_valid), 32'd1);
                    check("hold_data", 32'(bus.tx_data), 32'(pdata));
                end
                hs = bus.tx_data_valid && bus.tx_data_ready;
                if (hs) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(bus.tx_data), 32'(e));
                    end
                end
                pend  = bus.tx_data_valid && !hs;
                pdata = bus.tx_data;
            end
            @(posedge sys_clk);
            #1;
            if (hs)                 busy_left = busy_time;
            else if (busy_left > 0) busy_left--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        sys_rst_n      = 1'b0;
        bus.msg_valid  = 1'b0;
        bus.echo_valid = 1'b0;
        force_low      = 1'b0;
        busy_time      = 0;
        busy_left      = 0;
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the strobe edge.
    task automatic push_msg(input logic [NB*8-1:0] d, input bit exp_acc);
        bus.msg_data  = d;
        bus.msg_valid = 1'b1;
        check("msg_ready", 32'(bus.msg_ready), 32'(exp_acc));
        if (exp_acc) begin
            for (int i = 0; i < NB; i++) exp_q.push_back(d[(NB-1-i)*8 +: 8]);
        end
        @(posedge sys_clk);
        #1;
        bus.msg_valid = 1'b0;
    endtask

    task automatic pulse_echo(input logic [7:0] b);
        bus.echo_data  = b;
        bus.echo_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.echo_valid = 1'b0;
    endtask

    task automatic wait_hs_count(input int target, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge sys_clk);
            #1;
            if (hs_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_hs", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && !bus.tx_data_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 32'(ok), 32'd1);
        check("pending_bytes", 32'(exp_q.size()), 32'd0);
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int base;
        sys_rst_n      = 1'b1;
        bus.msg_valid  = 1'b0;
        bus.msg_data   = '0;
        bus.echo_valid = 1'b0;
        bus.echo_data  = 8'h00;
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_data_valid), 32'd0);
        check("rst_msg_ready", 32'(bus.msg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        @(posedge sys_clk);
        #1;
        apply_reset();

        // Single message, slow uart_tx.
        busy_time = 10;
        base = hs_count;
        push_msg(make_msg(1), 1'b1);
        check("lat_pre_valid", 32'(bus.tx_data_valid), 32'd0);
        @(posedge sys_clk);
        #1;
        check("lat_valid", 32'(bus.tx_data_valid), 32'd1);
        check("lat_first_byte", 32'(bus.tx_data), 32'h53);
        wait_idle(2000);
        check("single_bytes", 32'(hs_count - base), 32'd21);
        check("single_busy", 32'(busy), 32'd0);

        // FIFO full: third consecutive push refused.
        apply_reset();
        force_low = 1'b1;
        push_msg(make_msg(2), 1'b1);
        push_msg(make_msg(3), 1'b1);
        push_msg(make_msg(4), 1'b0);
        check("full_drop", 32'(drop_cnt), 32'd1);
        check("full_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge sys_clk);
        #1;
        force_low = 1'b0;
        busy_time = $urandom_range(0, 2);
        wait_idle(1000);
        check("full_drop_end", 32'(drop_cnt), 32'd1);

        // Echo during byte 5 lands between the two messages.
        apply_reset();
        busy_time = 1;
        base = hs_count;
        push_msg(make_msg(5), 1'b1);
        push_msg(make_msg(6), 1'b1);
        wait_hs_count(base + 5, 200);
        exp_q.insert(exp_q.size() - NB, 8'h41);
        pulse_echo(8'h41);
        wait_idle(1000);
        check("echo_mid_drop", 32'(drop_cnt), 32'd0);

        // Echo overflow, then a new echo on the handshake edge of the held one.
        apply_reset();
        force_low = 1'b1;
        pulse_echo(8'h31);
        pulse_echo(8'h32);
        check("echo_ovf_drop", 32'(drop_cnt), 32'd1);
        exp_q.push_back(8'h31);
        repeat (2) @(posedge sys_clk);
        #1;
        check("echo_ovf_state", 32'(fsm_state), 32'(ECHO));
        busy_time = 3;
        force_low = 1'b0;
        exp_q.push_back(8'h33);
        pulse_echo(8'h33);
        wait_idle(200);
        check("echo_ovf_drop_end", 32'(drop_cnt), 32'd1);

        // Asynchronous reset in the middle of a message.
        apply_reset();
        force_low = 1'b1;
        push_msg(make_msg(7), 1'b1);
        push_msg(make_msg(8), 1'b1);
        push_msg(make_msg(9), 1'b0);
        check("pre_rst_drop", 32'(drop_cnt), 32'd1);
        force_low = 1'b0;
        base = hs_count;
        wait_hs_count(base + 10, 200);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.tx_data_valid), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check("mid_rst_data", 32'(bus.tx_data), 32'h0);
        check("mid_rst_ready", 32'(bus.msg_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        push_msg(make_msg(2), 1'b1);
        @(posedge sys_clk);
        #1;
        check("post_rst_first", 32'(bus.tx_data), 32'h53);
        wait_idle(500);

        // Saturation of the drop counter.
        apply_reset();
        force_low = 1'b1;
        push_msg(make_msg(3), 1'b1);
        push_msg(make_msg(4), 1'b1);
        for (int i = 0; i < 300; i++) push_msg(make_msg(i % 10), 1'b0);
        check("sat_drop", 32'(drop_cnt), 32'd255);
        force_low = 1'b0;
        wait_idle(1000);
        check("sat_drop_end", 32'(drop_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
